debounce_botoes: RTL

Upstream conditioning stage for the push-button LED circuits. It takes raw, asynchronous, bouncing push-button pins, synchronizes each one to clk, and filters it with a stability counter. It then presents clean levels to the downstream logic: bit 0 drives pino2 and bit 1 drives pino3 of the OR/LED stage. It also emits one-cycle press and release pulses for future counting and toggling stages.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_canal.sv | 104 ++++++++++
 rtl/debounce_botoes.sv | 38 +++
 3 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared FSM encoding and default stability length for the
//               push-button debounce channels.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int c_ciclos_estavel_padrao = 16;

    // Bit 1 of the encoding is the debounced level seen downstream
    typedef enum logic [1:0] {
        ESTAVEL_0  = 2'b00,
        CONFIRMA_1 = 2'b01,
        ESTAVEL_1  = 2'b11,
        CONFIRMA_0 = 2'b10
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/debounce_canal.sv
`default_nettype none
// ============================================================================
// Module      : debounce_canal
// Description : One button channel: 2-flop synchronizer, stability FSM and
//               counter, with one-cycle press/release pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_canal
    import debounce_pkg::*;
#(
    parameter int CICLOS_ESTAVEL = c_ciclos_estavel_padrao,
    parameter int CNT_W          = $clog2(CICLOS_ESTAVEL)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_bruto,
    output logic o_limpo,
    output logic o_pulso_press,
    output logic o_pulso_solta
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(CICLOS_ESTAVEL - 1);
    localparam logic [CNT_W-1:0] c_cnt_um  = CNT_W'(1);

    logic             r_sync1;
    logic             r_s;
    estado_t          r_estado;
    estado_t          w_estado_prox;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_prox;
    logic             r_press;
    logic             r_solta;
    logic             w_press;
    logic             w_solta;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_s      <= 1'b0;
            r_estado <= ESTAVEL_0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
            r_solta  <= 1'b0;
        end else begin
            r_sync1  <= i_bruto;
            r_s      <= r_sync1;
            r_estado <= w_estado_prox;
            r_cnt    <= w_cnt_prox;
            r_press  <= w_press;
            r_solta  <= w_solta;
        end
    end

    // Any reversal during confirmation falls back with the count cleared
    always_comb begin
        w_estado_prox = r_estado;
        w_cnt_prox    = '0;
        w_press       = 1'b0;
        w_solta       = 1'b0;
        case (r_estado)
            ESTAVEL_0: begin
                if (r_s) begin
                    w_estado_prox = CONFIRMA_1;
                    w_cnt_prox    = c_cnt_um;
                end
            end
            CONFIRMA_1: begin
                if (!r_s) begin
                    w_estado_prox = ESTAVEL_0;
                end else if (r_cnt == c_cnt_max) begin
                    w_estado_prox = ESTAVEL_1;
                    w_press       = 1'b1;
                end else begin
                    w_cnt_prox = r_cnt + c_cnt_um;
                end
            end
            ESTAVEL_1: begin
                if (!r_s) begin
                    w_estado_prox = CONFIRMA_0;
                    w_cnt_prox    = c_cnt_um;
                end
            end
            CONFIRMA_0: begin
                if (r_s) begin
                    w_estado_prox = ESTAVEL_1;
                end else if (r_cnt == c_cnt_max) begin
                    w_estado_prox = ESTAVEL_0;
                    w_solta       = 1'b1;
                end else begin
                    w_cnt_prox = r_cnt + c_cnt_um;
                end
            end
            default: begin
                w_estado_prox = ESTAVEL_0;
            end
        endcase
    end

    assign o_limpo       = (r_estado == ESTAVEL_1) || (r_estado == CONFIRMA_0);
    assign o_pulso_press = r_press;
    assign o_pulso_solta = r_solta;

endmodule
`default_nettype wire

// File: rtl/debounce_botoes.sv
`default_nettype none
// ============================================================================
// Module      : debounce_botoes
// Description : Debounces N_BOTOES raw push-button pins into clean levels and
//               one-cycle press/release pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_botoes
    import debounce_pkg::*;
#(
    parameter int N_BOTOES       = 2,
    parameter int CICLOS_ESTAVEL = c_ciclos_estavel_padrao,
    parameter int CNT_W          = $clog2(CICLOS_ESTAVEL)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] botao_bruto,
    output logic [N_BOTOES-1:0] botao_limpo,
    output logic [N_BOTOES-1:0] pulso_press,
    output logic [N_BOTOES-1:0] pulso_solta
);

    for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
        debounce_canal #(
            .CICLOS_ESTAVEL (CICLOS_ESTAVEL),
            .CNT_W          (CNT_W)
        ) u_canal (
            .clk           (clk),
            .rst           (rst),
            .i_bruto       (botao_bruto[i]),
            .o_limpo       (botao_limpo[i]),
            .o_pulso_press (pulso_press[i]),
            .o_pulso_solta (pulso_solta[i])
        );
    end

endmodule
`default_nettype wire
